clock_phase_gen: RTL and testbench
==================================

Name: clock_phase_gen

Overview:
Parametrised successor of the fixed 10-phase machine clock generator. It produces an N-phase one-hot-low phase bus and K programmable strobe windows, such as ROM select, address strobe, RAS, CAS and RAM write. It adds a wait-state hold, a start-up delay and a cycle counter. It is clocked from the crystal and sits at the root of the emulator timing, driving every memory and bus strobe.

Parameters:
NPHASE, 10, number of phases per machine cycle (2..15)
NSTRB, 5, number of programmable strobe outputs
PW, 4, width of a phase index; must satisfy 2^PW > NPHASE
START_DLY, 2, idle cycles after reset release before phase 1 (0..15)
WAIT_PHASE, 3, phase in which wait_req is honoured
STRB_IDLE, {NSTRB{1'b1}}, idle (inactive) level per strobe bit
CW, 16, cycle counter width

Ports:
xtal_in  in  1  master clock; all state changes on its rising edge
init_n  in  1  asynchronous active-low reset
wait_req  in  1  stretch request, sampled only in WAIT_PHASE
strb_set  in  NSTRB*PW  per-strobe activate phase; strobe k uses bits [k*PW +: PW]
strb_clr  in  NSTRB*PW  per-strobe deactivate phase, same packing
tn  out  NPHASE  phase bus, bit p-1 low during phase p (one-hot-low)
phase  out  PW  current phase index; 0 = idle
strb  out  NSTRB  strobe outputs, registered
cyc_start  out  1  high for the single cycle in which phase 1 is entered
cyc_cnt  out  CW  count of completed machine cycles, wraps
waiting  out  1  high while the phase is held by wait_req

Behaviour:
- Reset (init_n low, asynchronous):
  - phase=0, tn all ones, strb=STRB_IDLE, cyc_start=0, cyc_cnt=0, waiting=0.
  - Start-up counter is loaded with START_DLY.
  - Reset asserted mid-cycle aborts the cycle immediately; there is no completion.
- Start-up:
  - After release, phase stays 0 while the start-up counter decrements once per edge.
  - On the edge where the counter is 0, phase becomes 1.
  - START_DLY=0 means phase 1 on the first edge after release.
- Sequencing:
  - Phase advances 1,2,...,NPHASE,1,... one step per edge.
  - tn is the registered one-hot-low decode of the next phase value. It changes on the same edge as phase; no glitch, no two zeros at once.
- cyc_start: registered, high for exactly the cycle following each entry into phase 1, including the first entry after start-up.
- cyc_cnt: increments on every NPHASE->1 transition and wraps at 2^CW. The first entry from idle does not count.
- Wait:
  - If phase==WAIT_PHASE and wait_req=1 at an edge, phase holds and waiting=1 for the next cycle.
  - The phase is released on the first edge with wait_req=0, so the stretch is unbounded.
  - wait_req in any other phase is ignored.
- Strobes are evaluated only on edges where phase changes. For each k, with P the new phase:
  - If P==clr_k, strobe k goes idle.
  - Else if P==set_k, strobe k goes active (~STRB_IDLE[k]).
  - Otherwise strobe k holds.
  - Result: strobe k is active during phases set_k..clr_k-1, modulo wrap, and is stretched by wait holds.
  - set_k==clr_k: strobe stays idle.
  - A value of 0 or >NPHASE never matches, so the strobe holds its current level.
- strb_set and strb_clr are expected static but are sampled every edge; a change takes effect at the next phase transition.
- All outputs are registered. No combinational path from inputs to outputs.

Optional Feature:
CLKGEN_STEP_EN:
- When defined, adds input ports step_mode (1 bit) and step (1 bit).
- step is synchronised by 2 flops and rising-edge detected.
- While step_mode=1, a phase transition (including leaving start-up) occurs only on an edge with a detected step rise. Wait and strobe rules still apply at that transition.
- step_mode=0: free-running behaviour as above.
- When not defined, the ports are absent and the block is always free-running.

Test Plan:
1. Defaults: release init_n at an edge. phase=0 for 2 edges, then 1; tn=10'h3FE; cyc_start=1 for that cycle. Phase 10 is followed by 1; cyc_cnt=1 after the first wrap.
2. Strobe windows: set=2/clr=6 (idle 1) gives strb[0] low in phases 2..5. set=9/clr=4 gives a wrapping window: active in phases 9,10,1,2,3.
3. Wait: wait_req=1 for 5 edges while phase=3. phase stays 3 for 6 cycles, waiting=1 for 5 cycles, and an active strobe stays active. With wait_req=1 in phase 5, there is no hold.
4. Degenerate: set=clr=4 gives a strobe that is always idle. set=0 or 12 gives a strobe that stays at its reset level. NPHASE=4 build sequences 1..4.
5. Reset mid-cycle: drop init_n in phase 7 with strobes active. All outputs return to reset values asynchronously, before the next edge, and START_DLY is re-applied after release.
6. With CLKGEN_STEP_EN and step_mode=1: phase advances exactly once per step pulse. Holding step high gives one advance only; step_mode=0 resumes free-running.

Source files
------------

// File: rtl/clock_phase_gen.sv
// Parametrised N-phase machine clock generator with K programmable strobe windows,
// a wait-state hold in one phase, a start-up delay after reset and a machine-cycle counter.
// Optional single-step support is compiled in with `define CLKGEN_STEP_EN.
module clock_phase_gen #(
  parameter int unsigned        NPHASE     = 10,
  parameter int unsigned        NSTRB      = 5,
  parameter int unsigned        PW         = 4,
  parameter int unsigned        START_DLY  = 2,
  parameter int unsigned        WAIT_PHASE = 3,
  parameter logic [NSTRB-1:0]   STRB_IDLE  = {NSTRB{1'b1}},
  parameter int unsigned        CW         = 16
) (
  input  logic                  xtal_in,
  input  logic                  init_n,
  input  logic                  wait_req,
`ifdef CLKGEN_STEP_EN
  input  logic                  step_mode,
  input  logic                  step,
`endif
  input  logic [NSTRB*PW-1:0]   strb_set,
  input  logic [NSTRB*PW-1:0]   strb_clr,
  output logic [NPHASE-1:0]     tn,
  output logic [PW-1:0]         phase,
  output logic [NSTRB-1:0]      strb,
  output logic                  cyc_start,
  output logic [CW-1:0]         cyc_cnt,
  output logic                  waiting
);

  localparam int unsigned SW = 4;
  localparam logic [PW-1:0] PH_IDLE  = PW'(0);
  localparam logic [PW-1:0] PH_FIRST = PW'(1);
  localparam logic [PW-1:0] PH_LAST  = PW'(NPHASE);
  localparam logic [PW-1:0] PH_WAIT  = PW'(WAIT_PHASE);
  localparam logic [SW-1:0] DLY_INIT = SW'(START_DLY);

  logic [SW-1:0]     dly_cnt;
  logic [SW-1:0]     dly_cnt_nxt;
  logic [PW-1:0]     phase_nxt;
  logic              advance;
  logic              hold;
  logic              step_ok;

  logic [NPHASE-1:0] tn_nxt;
  logic [NSTRB-1:0]  strb_nxt;
  logic              cyc_start_nxt;
  logic [CW-1:0]     cyc_cnt_nxt;
  logic              waiting_nxt;

`ifdef CLKGEN_STEP_EN
  logic [2:0] step_sync;

  // Two-flop synchroniser plus one extra stage for rising-edge detection of step
  always_ff @(posedge xtal_in or negedge init_n) begin
    if (!init_n) step_sync <= 3'b000;
    else         step_sync <= {step_sync[1:0], step};
  end

  assign step_ok = !step_mode || (step_sync[1] && !step_sync[2]);
`else
  assign step_ok = 1'b1;
`endif

  // Sequencer state register: phase index and start-up delay counter
  always_ff @(posedge xtal_in or negedge init_n) begin
    if (!init_n) begin
      phase   <= PH_IDLE;
      dly_cnt <= DLY_INIT;
    end else begin
      phase   <= phase_nxt;
      dly_cnt <= dly_cnt_nxt;
    end
  end

  // Next-state: leave idle after the start-up delay, advance each edge unless held in the wait phase
  always_comb begin
    phase_nxt   = phase;
    dly_cnt_nxt = dly_cnt;
    advance     = 1'b0;
    hold        = 1'b0;
    if (phase == PH_IDLE) begin
      if (dly_cnt != SW'(0)) begin
        dly_cnt_nxt = dly_cnt - SW'(1);
      end else if (step_ok) begin
        advance   = 1'b1;
        phase_nxt = PH_FIRST;
      end
    end else if (phase == PH_WAIT && wait_req) begin
      hold = 1'b1;
    end else if (step_ok) begin
      advance   = 1'b1;
      phase_nxt = (phase == PH_LAST) ? PH_FIRST : phase + PW'(1);
    end
  end

  // Output next-values: phase decode, strobe set/clear on phase change, cycle bookkeeping
  always_comb begin
    tn_nxt        = '1;
    strb_nxt      = strb;
    cyc_start_nxt = advance && (phase_nxt == PH_FIRST);
    cyc_cnt_nxt   = cyc_cnt;
    waiting_nxt   = hold;
    for (int p = 0; p < int'(NPHASE); p++) begin
      tn_nxt[p] = (phase_nxt != PW'(p + 1));
    end
    if (advance) begin
      if (phase == PH_LAST) cyc_cnt_nxt = cyc_cnt + CW'(1);
      // clear wins over set so set==clr leaves the strobe idle
      for (int k = 0; k < int'(NSTRB); k++) begin
        if (phase_nxt == strb_clr[k*PW +: PW])      strb_nxt[k] = STRB_IDLE[k];
        else if (phase_nxt == strb_set[k*PW +: PW]) strb_nxt[k] = ~STRB_IDLE[k];
      end
    end
  end

  // Output registers, all updated on the same edge as phase
  always_ff @(posedge xtal_in or negedge init_n) begin
    if (!init_n) begin
      tn        <= '1;
      strb      <= STRB_IDLE;
      cyc_start <= 1'b0;
      cyc_cnt   <= '0;
      waiting   <= 1'b0;
    end else begin
      tn        <= tn_nxt;
      strb      <= strb_nxt;
      cyc_start <= cyc_start_nxt;
      cyc_cnt   <= cyc_cnt_nxt;
      waiting   <= waiting_nxt;
    end
  end

endmodule

// File: tb/tb_clock_phase_gen.sv
// Scoreboard bench for clock_phase_gen: stimulus drives inputs at the falling edge and queues
// the expected post-edge state from a behavioural model; a monitor pops and compares.
module tb_clock_phase_gen;

  localparam int unsigned      NPHASE     = 10;
  localparam int unsigned      NSTRB      = 5;
  localparam int unsigned      PW         = 4;
  localparam int unsigned      START_DLY  = 2;
  localparam int unsigned      WAIT_PHASE = 3;
  localparam int unsigned      CW         = 16;
  localparam logic [NSTRB-1:0] STRB_IDLE  = {NSTRB{1'b1}};

  logic                xtal_in = 1'b0;
  logic                init_n  = 1'b0;
  logic                wait_req = 1'b0;
  logic [NSTRB*PW-1:0] strb_set = '0;
  logic [NSTRB*PW-1:0] strb_clr = '0;
  logic [NPHASE-1:0]   tn;
  logic [PW-1:0]       phase;
  logic [NSTRB-1:0]    strb;
  logic                cyc_start;
  logic [CW-1:0]       cyc_cnt;
  logic                waiting;

  clock_phase_gen #(
    .NPHASE(NPHASE), .NSTRB(NSTRB), .PW(PW), .START_DLY(START_DLY),
    .WAIT_PHASE(WAIT_PHASE), .STRB_IDLE(STRB_IDLE), .CW(CW)
  ) dut (
    .xtal_in(xtal_in), .init_n(init_n), .wait_req(wait_req),
`ifdef CLKGEN_STEP_EN
    .step_mode(1'b0), .step(1'b0),
`endif
    .strb_set(strb_set), .strb_clr(strb_clr),
    .tn(tn), .phase(phase), .strb(strb), .cyc_start(cyc_start),
    .cyc_cnt(cyc_cnt), .waiting(waiting)
  );

  always #5 xtal_in = ~xtal_in;

  typedef struct packed {
    logic [PW-1:0]     phase;
    logic [NPHASE-1:0] tn;
    logic [NSTRB-1:0]  strb;
    logic              cs;
    logic [CW-1:0]     cc;
    logic              waiting;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Behavioural model state
  int m_phase, m_cnt, m_cc;
  bit m_cs, m_wait;
  bit touched [NSTRB];
  int sset [NSTRB];
  int sclr [NSTRB];

  function automatic bit in_range(input int v);
    return v >= 1 && v <= int'(NPHASE);
  endfunction

  // Strobe level from the window definition: active for phases set..clr-1 (wrapping),
  // but only once the sequence has visited its set or clear phase since reset.
  function automatic logic strobe_level(input int k);
    bit act;
    logic [NSTRB-1:0] idle_v;
    idle_v = STRB_IDLE;
    act = 1'b0;
    if (m_phase != 0 && touched[k]) begin
      if (in_range(sset[k]) && in_range(sclr[k])) begin
        if (sset[k] == sclr[k])     act = 1'b0;
        else if (sset[k] < sclr[k]) act = (m_phase >= sset[k]) && (m_phase < sclr[k]);
        else                        act = (m_phase >= sset[k]) || (m_phase < sclr[k]);
      end else begin
        act = in_range(sset[k]);
      end
    end
    return act ? ~idle_v[k] : idle_v[k];
  endfunction

  function automatic void model_step(input logic r, input logic w);
    int np;
    if (!r) begin
      m_phase = 0; m_cnt = int'(START_DLY); m_cc = 0; m_cs = 1'b0; m_wait = 1'b0;
      for (int k = 0; k < int'(NSTRB); k++) touched[k] = 1'b0;
    end else begin
      np     = m_phase;
      m_cs   = 1'b0;
      m_wait = (m_phase == int'(WAIT_PHASE)) && w;
      if (m_phase == 0) begin
        if (m_cnt > 0) m_cnt--;
        else           np = 1;
      end else if (!m_wait) begin
        np = (m_phase % int'(NPHASE)) + 1;
        if (m_phase == int'(NPHASE)) m_cc = (m_cc + 1) % (1 << CW);
      end
      if (np != m_phase) begin
        m_cs = (np == 1);
        for (int k = 0; k < int'(NSTRB); k++)
          if (np == sset[k] || np == sclr[k]) touched[k] = 1'b1;
      end
      m_phase = np;
    end
  endfunction

  function automatic exp_t mk_exp();
    exp_t e;
    e.phase = PW'(m_phase);
    e.tn    = '1;
    if (m_phase != 0) e.tn[m_phase-1] = 1'b0;
    for (int k = 0; k < int'(NSTRB); k++) e.strb[k] = strobe_level(k);
    e.cs      = m_cs;
    e.cc      = CW'(m_cc);
    e.waiting = m_wait;
    return e;
  endfunction

  task automatic cfg(input int k, input int s, input int c);
    sset[k] = s;
    sclr[k] = c;
    strb_set[k*PW +: PW] = PW'(s);
    strb_clr[k*PW +: PW] = PW'(c);
  endtask

  // One falling-edge step: queue the expectation, then drive the inputs
  task automatic step(input logic r, input logic w);
    @(negedge xtal_in);
    model_step(r, w);
    q.push_back(mk_exp());
    wait_req = w;
    init_n   = r;
  endtask

  task automatic run_to(input int p);
    for (int i = 0; i < 40 && m_phase != p; i++) step(1'b1, 1'b0);
  endtask

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h at %0t", nm, act, req, $time);
    end
  endfunction

  // Monitor: compare after every rising edge and immediately after an asynchronous reset
  initial begin
    exp_t e;
    forever begin
      @(posedge xtal_in or negedge init_n);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("phase",     32'(phase),     32'(e.phase));
        chk("tn",        32'(tn),        32'(e.tn));
        chk("strb",      32'(strb),      32'(e.strb));
        chk("cyc_start", 32'(cyc_start), 32'(e.cs));
        chk("cyc_cnt",   32'(cyc_cnt),   32'(e.cc));
        chk("waiting",   32'(waiting),   32'(e.waiting));
      end
    end
  end

  initial begin
    int len;
    int drained;
    model_step(1'b0, 1'b0);

    // Episode 1: plain window, wrapping window, set==clr, set=0, set>NPHASE
    cfg(0, 2, 6); cfg(1, 9, 4); cfg(2, 4, 4); cfg(3, 0, 5); cfg(4, 12, 3);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    run_to(3);
    repeat (5) step(1'b1, 1'b1);
    step(1'b1, 1'b0);
    repeat (25) step(1'b1, 1'b0);
    run_to(4);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);

    // Episode 2: wait_req outside the wait phase is ignored; reset in phase 7 with strobes active
    cfg(0, 6, 9); cfg(1, 7, 2); cfg(2, 3, 8); cfg(3, 5, 15); cfg(4, 10, 1);
    run_to(5);
    step(1'b1, 1'b1);
    run_to(7);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);

    // Random episodes: random windows, random wait requests, reset at a random point
    for (int ep = 0; ep < 20; ep++) begin
      for (int k = 0; k < int'(NSTRB); k++)
        cfg(k, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
      len = int'($urandom_range(10, 60));
      for (int i = 0; i < len; i++) step(1'b1, ($urandom_range(0, 3) == 0));
      step(1'b0, 1'b0);
      step(1'b0, ($urandom_range(0, 1) == 1));
    end
    repeat (12) step(1'b1, 1'b0);

    drained = 0;
    for (int i = 0; i < 5 && q.size() != 0; i++) @(posedge xtal_in);
    #2;
    drained = q.size();
    chk("queue_drained", 32'(drained), 32'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
